// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared encodings for the iterative multiply/divide sequencer:
//                operation codes, FSM state enum and the divide-by-zero
//                quotient fill value.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation encodings on the op port
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MUL   = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Quotient returned on divide by zero; sliced to WIDTH (WIDTH <= 64)
    localparam logic [63:0] DZ_QUOTIENT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One radix-2 iteration on a 2*WIDTH+1 bit accumulator.
//                Multiply: conditional add of the multiplicand into the upper
//                half, then logical shift right.  Divide (restoring): shift
//                {rem, quo} left, subtract the divisor when it fits and set
//                the new quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_is_div,
    input  logic [2*WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH:0]   o_acc
);

    logic [WIDTH:0]   w_upper_sum;
    logic [2*WIDTH:0] w_mul_acc;
    logic [2*WIDTH:0] w_shift;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [2*WIDTH:0] w_div_acc;

    // Multiply path: the upper W+1 bits never overflow because the partial
    // product stays below 2^W before the add.
    assign w_upper_sum = i_acc[0] ? (i_acc[2*WIDTH:WIDTH] + {1'b0, i_opnd})
                                  : i_acc[2*WIDTH:WIDTH];
    assign w_mul_acc   = {1'b0, w_upper_sum, i_acc[WIDTH-1:1]};

    // Divide path: remainder is always below the divisor, so the top bit
    // dropped by the shift is zero.
    assign w_shift   = {i_acc[2*WIDTH-1:0], 1'b0};
    assign w_rem     = w_shift[2*WIDTH:WIDTH];
    assign w_fits    = (w_rem >= {1'b0, i_opnd});
    assign w_diff    = w_rem - {1'b0, i_opnd};
    assign w_div_acc = w_fits ? {w_diff, w_shift[WIDTH-1:1], 1'b1} : w_shift;

    assign o_acc = i_is_div ? w_div_acc : w_mul_acc;

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative MULT/MULTU/DIV/DIVU sequencer sharing one radix-2
//                engine.  Operands are latched on start, made magnitude-only
//                in PREP, iterated WIDTH times and sign-fixed in FIX; hi/lo
//                are presented with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div_by_zero;

    logic               w_is_div;
    logic               w_is_signed;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_prep_opnd;
    logic [2*WIDTH:0]   w_prep_acc;
    logic [2*WIDTH:0]   w_step_in;
    logic [WIDTH-1:0]   w_step_opnd;
    logic [2*WIDTH:0]   w_step_out;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_is_div    = (r_op == OP_DIVU) || (r_op == OP_DIV);
    assign w_is_signed = (r_op == OP_MUL)  || (r_op == OP_DIV);
    assign w_b_zero    = (r_b == '0);
    assign w_abs_a     = (w_is_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_abs_b     = (w_is_signed && r_b[WIDTH-1]) ? -r_b : r_b;

    // Multiply keeps the multiplier in the low half and adds the
    // multiplicand; divide keeps the dividend in the low half and compares
    // against the divisor.
    assign w_prep_opnd = w_is_div ? w_abs_b : w_abs_a;
    assign w_prep_acc  = {{(WIDTH+1){1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};

    // The PREP edge already performs iteration 0 on the freshly prepared
    // operands, so ITER runs steps 1..WIDTH-1 and FIX follows WIDTH edges
    // after PREP was entered.
    assign w_step_in   = (r_state == S_PREP) ? w_prep_acc  : r_acc;
    assign w_step_opnd = (r_state == S_PREP) ? w_prep_opnd : r_opnd;
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div (w_is_div),
        .i_acc    (w_step_in),
        .i_opnd   (w_step_opnd),
        .o_acc    (w_step_out)
    );

    assign w_prod     = r_acc[2*WIDTH-1:0];
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_acc[WIDTH-1:0];
    assign w_rem      = r_acc[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and busy decode; abort wins over everything, including start
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_next = S_PREP;
                end
            end
            S_PREP: begin
                busy = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_is_div && w_b_zero) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_ITER;
                end
            end
            S_ITER: begin
                busy = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration and result write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_opnd        <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dz          <= 1'b0;
            r_done        <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_a           <= a;
                        r_b           <= b;
                        r_op          <= op;
                        r_div_by_zero <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (!abort) begin
                        r_neg_q <= w_is_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                        r_neg_r <= w_is_signed & r_a[WIDTH-1];
                        r_dz    <= w_is_div & w_b_zero;
                        r_opnd  <= w_prep_opnd;
                        r_acc   <= w_step_out;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_ITER: begin
                    r_acc <= w_step_out;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (!abort) begin
                        r_done <= 1'b1;
                        if (r_dz) begin
                            r_hi          <= r_a;
                            r_lo          <= DZ_QUOTIENT[WIDTH-1:0];
                            r_div_by_zero <= 1'b1;
                        end else if (w_is_div) begin
                            r_lo <= r_neg_q ? -w_quo : w_quo;
                            r_hi <= r_neg_r ? -w_rem : w_rem;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Directed scoreboard bench for muldiv_seq.  Stimulus pushes
//                hand-computed hi/lo/div_by_zero into a queue; a negedge
//                monitor pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    muldiv_seq #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            chk("done_expected", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("hi", hi, mon_e.hi);
                chk("lo", lo, mon_e.lo);
                chk("div_by_zero", div_by_zero, mon_e.dz);
            end
        end
    end

    // Drive start for one edge; called at #1 after a posedge
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi);
        op    = o;
        a     = ai;
        b     = bi;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("dz_clear_on_start", div_by_zero, 0);
        chk("busy_after_start", busy, 1);
    endtask

    // Count edges until done; busy must stay high until then
    task automatic wait_done(input int lat);
        int k = 0;
        while (!done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (!done) chk("busy_during_op", busy, 1);
        end
        chk("latency", k, lat);
        chk("busy_low_at_done", busy, 0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                          input int lat);
        start_op(o, ai, bi);
        sb_q.push_back('{eh, el, edz});
        wait_done(lat);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_dz", div_by_zero, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back operations; each new start lands in the previous done cycle
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
        run_op(OP_MUL,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
        run_op(OP_MUL,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33);
        run_op(OP_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 2);
        run_op(OP_MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 33);

        // Start while busy is ignored
        start_op(OP_MULTU, 32'd7, 32'd9);
        sb_q.push_back('{32'd0, 32'd63, 1'b0});
        repeat (10) @(posedge clk);
        #1;
        op    = OP_DIVU;
        a     = 32'd5;
        b     = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(22);
        repeat (40) @(posedge clk);
        #1;

        // Abort in ITER: no done, previous results retained
        start_op(OP_MULTU, 32'd3, 32'd4);
        repeat (15) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 63);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_lo_kept", lo, 63);

        // Asynchronous reset mid-ITER clears outputs without a clock edge
        start_op(OP_DIVU, 32'd1000, 32'd3);
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_hi", hi, 0);
        chk("areset_lo", lo, 0);
        chk("areset_dz", div_by_zero, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        run_op(OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 33);
        @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer for the multi-cycle CPU. It replaces the single-cycle multiplier and divider behind the MUL/MULTU/DIV/DIVU paths with one shared radix-2 shift-add/shift-subtract engine. It accepts one operation at a time from the main control FSM and raises busy so control holds in execution. When the operation finishes it presents HI/LO results with a one-cycle done pulse for the HI/LO write-back.

Parameters:
WIDTH, 32, operand/result width (HI and LO are each WIDTH bits)
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MULTU, 01 MUL (signed), 10 DIVU, 11 DIV (signed)
a  input  WIDTH  multiplicand / dividend (rs), captured with start
b  input  WIDTH  multiplier / divisor (rt), captured with start
abort  input  1  synchronous cancel (exception flush)
busy  output  1  high from the cycle after start acceptance until done
done  output  1  single-cycle pulse; hi/lo valid in the same cycle
hi  output  WIDTH  product[2W-1:W] or remainder
lo  output  WIDTH  product[W-1:0] or quotient
div_by_zero  output  1  set with done when a divide had b==0; cleared at next accepted start

Behaviour:
- Reset (async): state=IDLE; busy, done, div_by_zero=0; hi, lo=0; counter=0; operand registers=0.
- States: IDLE, PREP, ITER, FIX.
- IDLE: start=1 -> latch a, b, op; clear div_by_zero; go to PREP. start=0 -> stay. done is low in every state except the cycle after leaving FIX.
- PREP:
  - Signed ops: replace each operand with its absolute value; record neg_q = a[W-1]^b[W-1] and neg_r = a[W-1].
  - Unsigned ops: neg flags = 0.
  - Clear the accumulator; counter=0.
  - Divide with b==0 -> go directly to FIX with the dz flag set. Otherwise go to ITER.
- ITER: exactly WIDTH steps, one per cycle. After step with counter==WIDTH-1, go to FIX.
  - Multiply step: if multiplier LSB=1, add multiplicand to the upper half of a 2W+1-bit accumulator; then shift right by 1.
  - Divide step (restoring): shift {rem, quo} left by 1; if rem >= divisor, subtract it and set quo LSB=1.
- FIX: register results, pulse done=1 for the following cycle, return to IDLE.
  - Multiply: if neg_q, {hi,lo} = two's-complement negation of the 2W product; else the product.
  - Divide: lo = neg_q ? -quo : quo; hi = neg_r ? -rem : rem.
  - Divide by zero: lo = all ones, hi = original a (unmodified, sign included), div_by_zero=1.
- Latency, counting the start-sampling edge as edge 0:
  - Normal op: PREP after edge 0, ITER edges 1..32, FIX after edge 32, done high after edge 33 (one cycle). A new start is accepted at edge 34 at the earliest.
  - Divide by zero: done high after edge 2.
- busy: high in PREP, ITER and FIX; low in IDLE.
- hi/lo hold their last results until the next FIX. They never change mid-operation.
- start while busy: ignored, no queuing. A start coincident with the done cycle is accepted, because the block is in IDLE then.
- abort (any non-IDLE state): next state IDLE, no done pulse, hi/lo/div_by_zero unchanged. abort has priority over start in IDLE.
- Reset mid-operation: immediate return to IDLE, all outputs zero.
- Signed corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
  - MUL 0x80000000 * 0x80000000: hi=0x40000000, lo=0.

Decomposition:
- muldiv_pkg: op encodings (OP_MULTU, OP_MUL, OP_DIVU, OP_DIV), state enum (S_IDLE, S_PREP, S_ITER, S_FIX), and the DZ_QUOTIENT constant (all ones).
- One natural sub-module, muldiv_step: combinational single iteration (add/shift or compare/subtract/shift) selected by an is_div input. It keeps the FSM file free of datapath arithmetic.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the start edge; busy high for cycles 1..33.
- MUL a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MUL 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> done 3 cycles after start, div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678. A following MULTU 2*3 clears div_by_zero and gives lo=6.
- Start pulsed at cycle 10 of a running op -> ignored; original result unchanged. Start in the done cycle -> accepted, second result correct.
- abort at ITER cycle 15 -> IDLE next cycle, no done, previous hi/lo kept. Async reset at ITER cycle 20 -> busy=0, hi=lo=0 immediately.
